// File: rtl/aes_inv_mixcolumns_iter.sv
// Iterative AES InvMixColumns: one column (or two with AES_INV_MC_DUAL_EN) per clock,
// valid/ready on both sides. Define AES_INV_MC_DUAL_EN for the two-datapath build.
//
// state | meaning
// IDLE  | in_ready high, waiting for a state
// BUSY  | transforming latched state, one slice per cycle
// DONE  | out_valid high, result held until out_ready
module aes_inv_mixcolumns_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

`ifdef AES_INV_MC_DUAL_EN
    localparam int COLS_PER_CYC = 2;
`else
    localparam int COLS_PER_CYC = 1;
`endif
    localparam int STEPS   = 4 / COLS_PER_CYC;
    localparam int CNT_W   = $clog2(STEPS);
    localparam int SLICE_W = 32 * COLS_PER_CYC;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                           state;
    logic [CNT_W-1:0]                 col;
    logic [STEPS-1:0][SLICE_W-1:0]    state_q;
    logic [STEPS-1:0][SLICE_W-1:0]    out_q;
    logic [SLICE_W-1:0]               slice_in;
    logic [SLICE_W-1:0]               slice_res;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] s  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [31:0] res;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            s[r]  = c[8*r +: 8];
            x2[r] = xt(s[r]);
            x4[r] = xt(x2[r]);
            x8[r] = xt(x4[r]);
            m9[r] = x8[r] ^ s[r];
            mb[r] = x8[r] ^ x2[r] ^ s[r];
            md[r] = x8[r] ^ x4[r] ^ s[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        for (int r = 0; r < 4; r++) begin
            res[8*r +: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
        end
        return res;
    endfunction

    assign slice_in = state_q[col];

    for (genvar g = 0; g < COLS_PER_CYC; g++) begin : g_col
        assign slice_res[32*g +: 32] = inv_mix_col(slice_in[32*g +: 32]);
    end

    assign state_out = out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            state_q   <= '0;
            out_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_q  <= state_in;
                        col      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    out_q[col] <= slice_res;
                    if (col == LAST) begin
                        col       <= '0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        col <= col + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_mixcolumns_iter.sv
// Directed + random bench for aes_inv_mixcolumns_iter; scoreboard queue of expected states.
module tb_aes_inv_mixcolumns_iter;

`ifdef AES_INV_MC_DUAL_EN
    localparam int LAT    = 2;
    localparam int PERIOD = 4;
`else
    localparam int LAT    = 4;
    localparam int PERIOD = 6;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] state_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] state_out;
    logic         busy;

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           t_acc = 0;
    int           prev_acc = 0;
    logic [127:0] sb_q [$];
    logic [127:0] exp_hold;
    logic [127:0] orig;
    logic         saw_valid;

    aes_inv_mixcolumns_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gx2(input logic [7:0] b);
        return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
    endfunction

    function automatic logic [127:0] fwd_mc(input logic [127:0] st);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = st[32*c + 8*r +: 8];
            for (int r = 0; r < 4; r++)
                o[32*c + 8*r +: 8] = gx2(a[r]) ^ gx2(a[(r+1)%4]) ^ a[(r+1)%4]
                                     ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge right after the acceptance edge.
    task automatic send(input logic [127:0] s, input logic [127:0] exp, input bit push);
        in_valid = 1'b1;
        state_in = s;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        check("accept_timeout", in_ready, 1);
        @(negedge clk);
        t_acc    = cyc;
        in_valid = 1'b0;
        state_in = rnd128();
        if (push) sb_q.push_back(exp);
    endtask

    task automatic recv(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        check({tag, "_valid_timeout"}, out_valid, 1);
        check({tag, "_latency"}, cyc - t_acc, LAT);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            exp_hold = '0;
        end else begin
            exp_hold = sb_q.pop_front();
            check({tag, "_data"}, state_out, exp_hold);
        end
        if (out_ready) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_state_out", state_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset during the second BUSY cycle
        send(128'h0123456789abcdef_fedcba9876543210, '0, 1'b0);
        check("busy_after_accept", busy, 1);
        check("in_ready_in_busy", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_state_out", state_out, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            saw_valid |= out_valid;
        end
        check("midrst_no_valid", saw_valid, 0);

        // Known-answer vector and identity columns
        send(128'hd6d7d5d5_01010101_9d58dc9f_bca14d8e, 128'hd5d4d4d4_01010101_5c220af2_455313db, 1'b1);
        recv("vector");
        send(128'h01010101_c6c6c6c6_00000000_ffffffff, 128'h01010101_c6c6c6c6_00000000_ffffffff, 1'b1);
        recv("identity");

        // Backpressure in DONE with ignored in_valid pulses
        out_ready = 1'b0;
        send(128'hd6d7d5d5_01010101_9d58dc9f_bca14d8e, 128'hd5d4d4d4_01010101_5c220af2_455313db, 1'b1);
        recv("bp");
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            state_in = rnd128();
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_state_out", state_out, exp_hold);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        check("bp_release_busy", busy, 0);
        check("bp_sb_drained", sb_q.size(), 0);

        // Random round-trip, back-to-back with out_ready tied high
        for (int n = 0; n < 1000; n++) begin
            orig = rnd128();
            send(fwd_mc(orig), orig, 1'b1);
            if (n > 0) check("rt_period", t_acc - prev_acc, PERIOD);
            prev_acc = t_acc;
            recv("rt");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
